// File: rtl/cnn_pkg.sv
// Shared constants for the CNN frame sequencer: FSM encoding,
// error codes, drain timeout default and expected-count helpers.
package cnn_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_CFG = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam int DRAIN_TIMEOUT_DEF = 2000;
    localparam int CNT_W             = 17;

    function automatic logic [CNT_W-1:0] conv_expect(
        input logic [7:0] w,
        input logic [7:0] h
    );
        return CNT_W'(w) * CNT_W'(h);
    endfunction

    // Valid 3x3 windows only exist when both dimensions are at least 3.
    function automatic logic [CNT_W-1:0] pool_expect(
        input logic [7:0] w,
        input logic [7:0] h
    );
        logic [CNT_W-1:0] a;
        logic [CNT_W-1:0] b;
        a = CNT_W'(w) - CNT_W'(2);
        b = CNT_W'(h) - CNT_W'(2);
        if (w >= 8'd3 && h >= 8'd3) begin
            return a * b;
        end
        return '0;
    endfunction

endpackage

// File: rtl/cnn_out_counter.sv
// Counts one datapath output strobe, compares against the expected
// total and flags any strobe that arrives once the total is reached.
module cnn_out_counter
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_strobe,
    input  logic [CNT_W-1:0] i_expected,
    output logic             o_match,
    output logic             o_overrun
);

    logic [CNT_W-1:0] r_count;
    logic             w_hit;

    assign w_hit     = i_en && i_strobe;
    assign o_match   = (r_count == i_expected);
    assign o_overrun = w_hit && o_match;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (w_hit && !o_match) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer: streams a WxH frame from the frame buffer into the
// CNN datapath and tracks its output strobes until the frame drains.
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            cfg_width,
    input  logic [7:0]            cfg_height,
    input  logic                  pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_in,
    output logic [DATA_WIDTH-1:0] pixel_in,
    output logic [7:0]            img_width,
    output logic [7:0]            img_height,
    input  logic                  valid_conv0,
    input  logic                  valid_pool0,
    input  logic                  valid_conv1,
    input  logic                  valid_pool1,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    logic [1:0]       r_state;
    logic [7:0]       r_width;
    logic [7:0]       r_height;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_exp_conv;
    logic [CNT_W-1:0] r_exp_pool;
    logic             r_valid;
    logic [31:0]      r_drain_cnt;
    logic [1:0]       r_err_code;

    logic             w_start_ok;
    logic             w_cfg_bad;
    logic             w_busy;
    logic             w_rd_en;
    logic [3:0]       w_strobe;
    logic [3:0]       w_match;
    logic [3:0]       w_ovr;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_cfg_bad  = (cfg_width == 8'd0) || (cfg_height == 8'd0);
    assign w_busy     = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign w_rd_en    = (r_state == S_STREAM) && !pause &&
                        (r_fetch_cnt < r_exp_conv);
    assign w_strobe   = {valid_pool1, valid_conv1,
                         valid_pool0, valid_conv0};

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        cnn_out_counter u_cnt (
            .clk        (clk),
            .rst        (rst),
            .i_clr      (w_start_ok),
            .i_en       (w_busy),
            .i_strobe   (w_strobe[g]),
            .i_expected ((g % 2 == 1) ? r_exp_pool : r_exp_conv),
            .o_match    (w_match[g]),
            .o_overrun  (w_ovr[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_fetch_cnt <= '0;
            r_exp_conv  <= '0;
            r_exp_pool  <= '0;
            r_valid     <= 1'b0;
            r_drain_cnt <= '0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_valid <= w_rd_en;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_width     <= cfg_width;
                        r_height    <= cfg_height;
                        r_fetch_cnt <= '0;
                        r_drain_cnt <= '0;
                        r_exp_conv  <= conv_expect(cfg_width, cfg_height);
                        r_exp_pool  <= pool_expect(cfg_width, cfg_height);
                        if (w_cfg_bad) begin
                            r_err_code <= ERR_BAD_CFG;
                            r_state    <= S_DONE;
                        end else begin
                            r_err_code <= ERR_NONE;
                            r_state    <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_rd_en) begin
                        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
                    end
                    // r_valid here is the trailing pixel of the last read
                    if (r_fetch_cnt == r_exp_conv && r_valid) begin
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 32'd1;
                    if (&w_match) begin
                        r_state <= S_DONE;
                    end else if (r_drain_cnt == 32'(DRAIN_TIMEOUT - 1)) begin
                        r_state <= S_DONE;
                        if (r_err_code == ERR_NONE) begin
                            r_err_code <= ERR_TIMEOUT;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_busy && (|w_ovr) && r_err_code == ERR_NONE) begin
                r_err_code <= ERR_OVERRUN;
            end
        end
    end

    // Read data comes straight off the RAM output register.
    assign mem_rd_en  = w_rd_en;
    assign mem_addr   = w_rd_en ? ADDR_WIDTH'(r_fetch_cnt) : '0;
    assign valid_in   = r_valid;
    assign pixel_in   = r_valid ? mem_rd_data : '0;
    assign img_width  = r_width;
    assign img_height = r_height;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign err_code   = r_err_code;
    assign err        = (r_err_code != ERR_NONE);

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer with a synchronous RAM
// model and a scripted datapath strobe generator.
module tb_cnn_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic        pause;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data;
    logic        valid_in;
    logic [15:0] pixel_in;
    logic [7:0]  img_width;
    logic [7:0]  img_height;
    logic        vc0, vp0, vc1, vp1;
    logic        busy, done, err;
    logic [1:0]  err_code;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_rd  = 0;
    int          n_vld = 0;
    int          cyc;
    logic [15:0] salt = 16'h1234;
    logic [15:0] q_addr[$];
    logic [15:0] q_pix[$];

    always #5 clk = ~clk;

    cnn_frame_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .pause       (pause),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .valid_in    (valid_in),
        .pixel_in    (pixel_in),
        .img_width   (img_width),
        .img_height  (img_height),
        .valid_conv0 (vc0),
        .valid_pool0 (vp0),
        .valid_conv1 (vc1),
        .valid_pool1 (vp1),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    function automatic logic [15:0] pix(input logic [15:0] a);
        return (a * 16'd37) ^ salt;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= pix(mem_addr);
    end

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic chk_zero();
        chk("z_rd_en",  32'(mem_rd_en), 0);
        chk("z_addr",   32'(mem_addr), 0);
        chk("z_valid",  32'(valid_in), 0);
        chk("z_pixel",  32'(pixel_in), 0);
        chk("z_img_w",  32'(img_width), 0);
        chk("z_img_h",  32'(img_height), 0);
        chk("z_busy",   32'(busy), 0);
        chk("z_done",   32'(done), 0);
        chk("z_err",    32'(err), 0);
        chk("z_code",   32'(err_code), 0);
    endtask

    task automatic mon();
        if (mem_rd_en) begin
            n_rd++;
            chk("rd_in_pause", 32'(pause), 0);
            chk("rd_expected", 32'(q_addr.size() != 0), 1);
            if (q_addr.size() != 0)
                chk("rd_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
        end
        if (valid_in) begin
            n_vld++;
            chk("vld_expected", 32'(q_pix.size() != 0), 1);
            if (q_pix.size() != 0)
                chk("pixel", 32'(pixel_in), 32'(q_pix.pop_front()));
        end
        if (!busy) chk("rd_when_idle", 32'(mem_rd_en), 0);
    endtask

    task automatic push_frame(input int n);
        salt = salt + 16'h0101;
        for (int i = 0; i < n; i++) begin
            q_addr.push_back(16'(i));
            q_pix.push_back(pix(16'(i)));
        end
    endtask

    task automatic run_frame(input int w, input int h,
                             input int p_at, input int p_len,
                             input int n0, input int n1,
                             input int n2, input int n3,
                             input int exp_code, input int budget);
        int  r0, r1, r2, r3, p_cnt, rd0, vd0, n_exp;
        bit  got;
        n_exp = (w == 0 || h == 0) ? 0 : w * h;
        push_frame(n_exp);
        rd0 = n_rd; vd0 = n_vld; got = 0; p_cnt = 0;
        r0 = n0; r1 = n1; r2 = n2; r3 = n3;
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 8'(w); cfg_height = 8'(h);
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        @(negedge clk);
        chk("img_w", 32'(img_width), w);
        chk("img_h", 32'(img_height), h);
        chk("busy", 32'(busy), 32'(n_exp != 0));
        while (cyc < budget) begin
            mon();
            if (done) begin
                got = 1;
                break;
            end
            if (mem_rd_en && p_at >= 0 && 32'(mem_addr) == p_at)
                p_cnt = p_len;
            @(posedge clk); #1;
            pause = (p_cnt > 0);
            if (p_cnt > 0) p_cnt--;
            vc0 = (r0 > 0); if (r0 > 0) r0--;
            vp0 = (r1 > 0); if (r1 > 0) r1--;
            vc1 = (r2 > 0); if (r2 > 0) r2--;
            vp1 = (r3 > 0); if (r3 > 0) r3--;
            // mid-frame start with another config must be ignored
            start = (cyc == 10);
            if (cyc == 10) begin
                cfg_width = 8'd3; cfg_height = 8'd3;
            end
            cyc++;
            @(negedge clk);
        end
        {vc0, vp0, vc1, vp1} = '0;
        pause = 1'b0; start = 1'b0;
        chk("done_seen", 32'(got), 1);
        chk("err_code", 32'(err_code), exp_code);
        chk("err", 32'(err), 32'(exp_code != 0));
        chk("img_w_hold", 32'(img_width), w);
        chk("n_rd", n_rd - rd0, n_exp);
        chk("n_vld", n_vld - vd0, n_exp);
        chk("q_left", q_addr.size() + q_pix.size(), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("err_hold", 32'(err), 32'(exp_code != 0));
        q_addr.delete();
        q_pix.delete();
    endtask

    initial begin
        bit hit;
        rst = 1'b1; start = 1'b0; pause = 1'b0;
        cfg_width = '0; cfg_height = '0;
        {vc0, vp0, vc1, vp1} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero();
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(8, 8, -1, 0, 64, 36, 64, 36, 0, 400);
        run_frame(8, 8, 20, 5, 64, 36, 64, 36, 0, 400);
        run_frame(0, 8, -1, 0, 0, 0, 0, 0, 1, 10);
        chk("badcfg_lat", 32'(cyc <= 2), 1);
        run_frame(8, 8, -1, 0, 63, 36, 64, 36, 2, 2300);
        chk("timeout_lat", 32'(cyc >= 2060 && cyc <= 2070), 1);
        run_frame(2, 2, -1, 0, 4, 1, 4, 0, 3, 100);

        push_frame(64);
        hit = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 8'd8; cfg_height = 8'd8;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            mon();
            if (mem_rd_en && mem_addr == 16'd30) begin
                hit = 1;
                break;
            end
        end
        chk("rst_addr30_seen", 32'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        q_addr.delete();
        q_pix.delete();
        run_frame(4, 4, -1, 0, 16, 4, 16, 4, 0, 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
